// File: rtl/aes_inv_round_ctrl.sv
// ============================================================================
// Module   : aes_inv_round_ctrl
// Purpose  : Round sequencer for an iterative AES-128/256 inverse cipher.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_inv_round_ctrl #(
    parameter int NR128 = 10,
    parameter int NR256 = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_key_size,
    input  logic       i_key_valid,
    input  logic       i_abort,
    output logic       o_in_ready,
    output logic       o_busy,
    output logic [3:0] o_key_idx,
    output logic       o_state_load,
    output logic       o_inv_mix_en,
    output logic       o_state_en,
    output logic       o_done
);

    localparam logic [3:0] C_NR128 = 4'(NR128);
    localparam logic [3:0] C_NR256 = 4'(NR256);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       r_key_size;
    logic       w_key_size_next;
    logic [3:0] w_nr;
    logic [3:0] w_idx;

    // The index is clamped to the latched round count so it can never exceed Nr.
    assign w_nr  = r_key_size ? C_NR256 : C_NR128;
    assign w_idx = (r_cnt > w_nr) ? w_nr : r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_key_size <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_key_size <= w_key_size_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        w_cnt_next      = r_cnt;
        w_key_size_next = r_key_size;
        o_in_ready      = 1'b0;
        o_busy          = 1'b0;
        o_key_idx       = 4'd0;
        o_state_load    = 1'b0;
        o_inv_mix_en    = 1'b0;
        o_state_en      = 1'b0;
        o_done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_in_ready = 1'b1;
                if (i_start) begin
                    w_key_size_next = i_key_size;
                    w_cnt_next      = i_key_size ? C_NR256 : C_NR128;
                    w_next          = S_INIT;
                end
            end
            S_INIT: begin
                o_busy       = 1'b1;
                o_state_load = 1'b1;
                o_key_idx    = w_idx;
                if (i_abort) begin
                    w_cnt_next = 4'd0;
                    w_next     = S_IDLE;
                end else if (i_key_valid) begin
                    o_state_en = 1'b1;
                    if (r_cnt != 4'd0) begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                    w_next = S_ROUND;
                end
            end
            S_ROUND: begin
                o_busy       = 1'b1;
                o_inv_mix_en = 1'b1;
                o_key_idx    = w_idx;
                if (i_abort) begin
                    w_cnt_next = 4'd0;
                    w_next     = S_IDLE;
                end else if (i_key_valid) begin
                    o_state_en = 1'b1;
                    if (r_cnt != 4'd0) begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                    if (r_cnt <= 4'd1) begin
                        w_next = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                o_busy = 1'b1;
                if (i_abort) begin
                    w_cnt_next = 4'd0;
                    w_next     = S_IDLE;
                end else if (i_key_valid) begin
                    o_state_en = 1'b1;
                    w_next     = S_DONE;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: constant vector table, directed corner sequences,
// and random stimulus against a key-consumption reference model.
`default_nettype none

module tb_aes_inv_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_key_size = 1'b0;
    logic       i_key_valid = 1'b0;
    logic       i_abort = 1'b0;
    logic       o_in_ready;
    logic       o_busy;
    logic [3:0] o_key_idx;
    logic       o_state_load;
    logic       o_inv_mix_en;
    logic       o_state_en;
    logic       o_done;

    int checks = 0;
    int errors = 0;

    aes_inv_round_ctrl #(.NR128(10), .NR256(14)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_key_size   (i_key_size),
        .i_key_valid  (i_key_valid),
        .i_abort      (i_abort),
        .o_in_ready   (o_in_ready),
        .o_busy       (o_busy),
        .o_key_idx    (o_key_idx),
        .o_state_load (o_state_load),
        .o_inv_mix_en (o_inv_mix_en),
        .o_state_en   (o_state_en),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    // Reference model: a block is a list of Nr+1 keys consumed in descending order.
    bit m_active;
    bit m_done;
    int m_nr;
    int m_pos;

    function automatic logic [9:0] pack(bit rdy, bit bsy, bit ld, bit mix, bit en, bit dn, int idx);
        logic [3:0] k;
        k = 4'(idx);
        return {rdy, bsy, ld, mix, en, dn, k};
    endfunction

    function automatic logic [9:0] obs_vec();
        return {o_in_ready, o_busy, o_state_load, o_inv_mix_en, o_state_en, o_done, o_key_idx};
    endfunction

    function automatic logic [9:0] model_vec(bit kv, bit ab);
        if (m_done)
            return pack(0, 0, 0, 0, 0, 1, 0);
        if (m_active)
            return pack(0, 1, m_pos == 0, (m_pos > 0) && (m_pos < m_nr), kv && !ab, 0, m_nr - m_pos);
        return pack(1, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_done   = 0;
        m_nr     = 0;
        m_pos    = 0;
    endtask

    task automatic model_edge(bit s, bit ks, bit kv, bit ab);
        if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (ab) begin
                m_active = 0;
            end else if (kv) begin
                if (m_pos == m_nr) begin
                    m_active = 0;
                    m_done   = 1;
                end else begin
                    m_pos++;
                end
            end
        end else if (s) begin
            m_active = 1;
            m_nr     = ks ? 14 : 10;
            m_pos    = 0;
        end
    endtask

    function automatic int model_idx();
        return (m_active && !m_done) ? (m_nr - m_pos) : -1;
    endfunction

    task automatic check(string name, logic [9:0] act, logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at posedge+1: drive, compare mid-cycle against the model, advance one edge.
    task automatic step(input bit s, input bit ks, input bit kv, input bit ab, output logic [9:0] obs);
        i_start     = s;
        i_key_size  = ks;
        i_key_valid = kv;
        i_abort     = ab;
        #4;
        obs = obs_vec();
        check("model", obs, model_vec(kv, ab));
        @(posedge clk);
        #1;
        model_edge(s, ks, kv, ab);
    endtask

    task automatic run_block(input bit ks, input int stall_idx, input int stall_n,
                             output int done_cycle, output int en_cycles);
        logic [9:0] v;
        int stalls;
        bit kv;
        stalls     = 0;
        done_cycle = -1;
        en_cycles  = 0;
        step(1, ks, 1, 0, v);
        for (int k = 1; k <= 40; k++) begin
            kv = !(model_idx() == stall_idx && stalls < stall_n);
            if (!kv) stalls++;
            step(0, !ks, kv, 0, v);
            if (v[5]) en_cycles++;
            if (v[4]) begin
                done_cycle = k;
                break;
            end
        end
    endtask

    typedef struct {
        bit         s;
        bit         ks;
        bit         kv;
        bit         ab;
        logic [9:0] exp;
    } vec_t;

    initial begin
        vec_t       tbl[10];
        logic [9:0] v;
        int         dc;
        int         en;
        int         ready_cnt;
        int         dones;
        bit         late_done;

        tbl[0] = '{0, 0, 0, 0, pack(1, 0, 0, 0, 0, 0, 0)};
        tbl[1] = '{1, 0, 0, 0, pack(1, 0, 0, 0, 0, 0, 0)};
        tbl[2] = '{0, 0, 0, 0, pack(0, 1, 1, 0, 0, 0, 10)};
        tbl[3] = '{0, 0, 1, 1, pack(0, 1, 1, 0, 0, 0, 10)};
        tbl[4] = '{1, 1, 0, 1, pack(1, 0, 0, 0, 0, 0, 0)};
        tbl[5] = '{0, 0, 1, 0, pack(0, 1, 1, 0, 1, 0, 14)};
        tbl[6] = '{1, 0, 1, 0, pack(0, 1, 0, 1, 1, 0, 13)};
        tbl[7] = '{0, 0, 0, 0, pack(0, 1, 0, 1, 0, 0, 12)};
        tbl[8] = '{0, 0, 1, 1, pack(0, 1, 0, 1, 0, 0, 12)};
        tbl[9] = '{0, 0, 0, 0, pack(1, 0, 0, 0, 0, 0, 0)};

        model_reset();
        #3;
        check("reset_outputs", obs_vec(), pack(1, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].s, tbl[i].ks, tbl[i].kv, tbl[i].ab, v);
            check($sformatf("table_row%0d", i), v, tbl[i].exp);
        end

        run_block(0, -1, 0, dc, en);
        check_int("aes128_done_latency", dc, 12);
        check_int("aes128_state_en_cycles", en, 11);
        step(0, 0, 0, 0, v);

        run_block(1, -1, 0, dc, en);
        check_int("aes256_done_latency", dc, 16);
        check_int("aes256_state_en_cycles", en, 15);
        step(0, 0, 0, 0, v);

        run_block(0, 5, 3, dc, en);
        check_int("stall_done_latency", dc, 15);
        check_int("stall_state_en_cycles", en, 11);
        step(0, 0, 0, 0, v);

        // abort at key index 7, then a fresh full run
        step(1, 0, 1, 0, v);
        for (int k = 0; k < 20 && model_idx() != 7; k++) step(0, 0, 1, 0, v);
        check_int("abort_reached_idx7", int'(o_key_idx), 7);
        step(0, 0, 1, 1, v);
        step(0, 0, 0, 0, v);
        check("abort_returns_idle", v, pack(1, 0, 0, 0, 0, 0, 0));
        run_block(0, -1, 0, dc, en);
        check_int("after_abort_latency", dc, 12);
        step(0, 0, 0, 0, v);

        // start held high: exactly one IDLE cycle between done pulses
        dones = 0;
        ready_cnt = 0;
        for (int k = 0; k < 60 && dones < 2; k++) begin
            step(1, 0, 1, 0, v);
            if (v[4]) dones++;
            else if (dones == 1 && v[9]) ready_cnt++;
        end
        check_int("b2b_done_pulses", dones, 2);
        check_int("b2b_idle_cycles", ready_cnt, 1);
        while (model_idx() != -1 || m_done) step(0, 0, 1, 0, v);

        // asynchronous reset in the middle of a block
        step(1, 0, 1, 0, v);
        for (int k = 0; k < 20 && model_idx() != 3; k++) step(0, 0, 1, 0, v);
        i_start = 1'b0;
        i_key_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", obs_vec(), pack(1, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        late_done = 0;
        for (int k = 0; k < 15; k++) begin
            step(0, 0, 1, 0, v);
            if (v[4]) late_done = 1;
        end
        check_int("no_done_after_reset", int'(late_done), 0);

        // random stimulus against the model
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 4) != 0,
                 $urandom_range(0, 40) == 0, v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
